// File: rtl/pid_pkg.sv
// Shared PID-loop package: error width, error type and clamp limits.
package pid_pkg;

  localparam int unsigned ERR_W = 9;

  typedef logic signed [ERR_W-1:0] err_t;

  localparam int ERR_MAX = 255;
  localparam int ERR_MIN = -256;

endpackage : pid_pkg

// File: rtl/sat_sub.sv
// Saturating signed subtract y = sat(a - b), reusable by the P/I/D stages.
// Ports:
//   a, b   : signed W-bit operands
//   y_c    : combinational difference, clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf_c  : combinational flag, high when the true difference was clipped
module sat_sub
  import pid_pkg::*;
#(
  parameter int unsigned W = ERR_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y_c,
  output logic                ovf_c
);

  // One extra bit holds the full difference range without wrap.
  logic [W:0] diff;
  logic       ovf;

  assign diff = {a[W-1], a} - {b[W-1], b};

  // Overflow when the top two bits disagree; clamp toward the sign.
  always_comb begin
    ovf = diff[W] ^ diff[W-1];
    y_c = diff[W-1:0];
    if (ovf) begin
      y_c = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    ovf_c = ovf;
  end

endmodule : sat_sub

// File: rtl/d_error.sv
// Discrete derivative stage: DErr = sat(Err[n] - Err[n-1]) sampled every
// SAMPLE_DIV clocks. The first sample after reset only primes the history.
// Ports:
//   clk_32   : system clock, rising edge
//   rst      : synchronous active-high reset
//   Err      : signed error input
//   DErr     : registered, saturated derivative
//   derr_sat : registered flag, high while DErr holds a clipped value
module d_error
  import pid_pkg::*;
#(
  parameter int unsigned W          = ERR_W,
  parameter int unsigned SAMPLE_DIV = 1
) (
  input  logic                clk_32,
  input  logic                rst,
  input  logic signed [W-1:0] Err,
  output logic signed [W-1:0] DErr,
  output logic                derr_sat
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0]    cnt;
  logic                strobe;
  logic                primed;
  logic signed [W-1:0] prev_err;
  logic signed [W-1:0] diff_sat_c;
  logic                diff_ovf_c;

  // Decimation strobe on the last count of each period.
  assign strobe = (cnt == CNT_W'(SAMPLE_DIV - 1));

  sat_sub #(.W(W)) u_sat_sub (
    .a     (Err),
    .b     (prev_err),
    .y_c   (diff_sat_c),
    .ovf_c (diff_ovf_c)
  );

  // Counter, history and output registers; reset takes priority over strobe.
  always_ff @(posedge clk_32) begin
    if (rst) begin
      cnt      <= '0;
      primed   <= 1'b0;
      prev_err <= '0;
      DErr     <= '0;
      derr_sat <= 1'b0;
    end else begin
      cnt <= strobe ? '0 : cnt + CNT_W'(1);
      if (strobe) begin
        prev_err <= Err;
        if (!primed) begin
          primed   <= 1'b1;
          DErr     <= '0;
          derr_sat <= 1'b0;
        end else begin
          DErr     <= diff_sat_c;
          derr_sat <= diff_ovf_c;
        end
      end
    end
  end

endmodule : d_error

// File: tb/tb_d_error.sv
// Self-checking bench for d_error: two instances (SAMPLE_DIV 1 and 4) share
// clock, reset and Err, and are compared every edge against an integer model.
module tb_d_error;

  logic              clk_32;
  logic              rst;
  logic signed [8:0] err;
  logic signed [8:0] derr1, derr4;
  logic              sat1, sat4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 -> divide by 1, index 1 -> divide by 4.
  int div    [2] = '{1, 4};
  int m_k    [2];
  int m_prev [2];
  int m_prim [2];
  int m_derr [2];
  int m_sat  [2];

  d_error u_dut1 (
    .clk_32   (clk_32),
    .rst      (rst),
    .Err      (err),
    .DErr     (derr1),
    .derr_sat (sat1)
  );

  d_error #(.SAMPLE_DIV(4)) u_dut4 (
    .clk_32   (clk_32),
    .rst      (rst),
    .Err      (err),
    .DErr     (derr4),
    .derr_sat (sat4)
  );

  initial clk_32 = 1'b0;
  always #5 clk_32 = ~clk_32;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the behavioural rules.
  task automatic model_edge(input logic r, input int e);
    int d;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_k[i] = 0; m_prev[i] = 0; m_prim[i] = 0; m_derr[i] = 0; m_sat[i] = 0;
      end else begin
        m_k[i]++;
        if (m_k[i] % div[i] == 0) begin
          if (m_prim[i] == 0) begin
            m_prim[i] = 1; m_derr[i] = 0; m_sat[i] = 0;
          end else begin
            d = e - m_prev[i];
            m_sat[i]  = (d > 255 || d < -256) ? 1 : 0;
            m_derr[i] = (d > 255) ? 255 : (d < -256) ? -256 : d;
          end
          m_prev[i] = e;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input int e);
    rst = r;
    err = 9'(e);
    @(posedge clk_32);
    model_edge(r, e);
    #1;
    check("derr_div1", derr1, m_derr[0]);
    check("sat_div1",  int'(sat1), m_sat[0]);
    check("derr_div4", derr4, m_derr[1]);
    check("sat_div4",  int'(sat4), m_sat[1]);
  endtask

  task automatic hold(input int e, input int n);
    for (int j = 0; j < n; j++) drive(1'b0, e);
  endtask

  initial begin
    int e;
    rst = 1'b1;
    err = '0;
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_prev[i] = 0; m_prim[i] = 0; m_derr[i] = 0; m_sat[i] = 0;
    end

    // Reset with Err=45, then release holding 45: everything stays 0.
    for (int j = 0; j < 3; j++) drive(1'b1, 45);
    hold(45, 10);

    // Positive step 0 -> 45, then hold.
    hold(0, 8);
    hold(45, 8);

    // Negative step 100 -> -20.
    hold(100, 8);
    hold(-20, 8);

    // Saturation both ways.
    hold(-256, 8);
    hold(255, 8);
    hold(-256, 8);
    hold(-256, 4);

    // Decimation step 10 -> 30.
    hold(10, 8);
    hold(30, 8);

    // Mid-run reset while DErr=45, then a large jump after release.
    hold(0, 8);
    drive(1'b0, 45);
    drive(1'b1, 45);
    hold(-200, 10);

    // Randomized Err with occasional holds and resets.
    e = 0;
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 2) == 0) e = int'($urandom_range(0, 511)) - 256;
      drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_d_error

// File: doc/d_error.md
# d_error

Discrete derivative stage for the BLDC controller's PID loop. It samples the signed speed/position error `Err` on `clk_32` and outputs the saturated backward difference `DErr = Err[n] − Err[n−1]`. `DErr` feeds the D-term multiplier. The block is purely registered, with no handshake: it samples continuously at a programmable decimated rate.

## Interface
- `W`, 9: error and derivative width, two's-complement signed.
- `SAMPLE_DIV`, 1: take one sample every `SAMPLE_DIV` clocks. Legal range 1..256.
- `clk_32`  in  1: system clock. All logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `Err`  in  W: current error, signed.
- `DErr`  out  W: registered derivative, signed, saturated.
- `derr_sat`  out  1: high while the current `DErr` value was clipped.

## Operation
- **Internal state**
  - `prev_err` [W]: last sampled error.
  - `primed` flag.
  - Divider counter, `ceil(log2(SAMPLE_DIV))` bits, minimum 1.
- **Sample strobe**
  - The counter counts 0..`SAMPLE_DIV`−1 and wraps.
  - The strobe is asserted when the counter equals `SAMPLE_DIV`−1.
  - With `SAMPLE_DIV`=1 the strobe is high every cycle.
- **On strobe**
  - `diff` = sign-extend(`Err`) − sign-extend(`prev_err`), computed at W+1 bits (range −511..+511 for W=9).
  - If `primed`=0: `DErr`←0, `derr_sat`←0, `primed`←1.
  - Otherwise: `DErr`←sat(`diff`) and `derr_sat`←(`diff` outside [−2^(W−1), 2^(W−1)−1]).
  - `prev_err`←`Err` in every case.
- **Saturation**
  - Positive overflow clamps to 2^(W−1)−1 (255).
  - Negative overflow clamps to −2^(W−1) (−256).
  - Values in range pass unchanged.
- **Between strobes:** `DErr`, `derr_sat` and `prev_err` hold.
- **Reset** clears all of the following:
  - `DErr`=0, `derr_sat`=0, `prev_err`=0, `primed`=0, counter=0.
  - The first strobe after reset only primes `prev_err`, so no spurious step appears from the reset value.
- **Reset mid-operation:** state is discarded and the block re-primes.
- **`rst` and strobe in the same cycle:** reset wins.
- **X on `Err`:** no filtering; the result is undefined until a clean sample has passed through `prev_err`.

## Timing
- **Latency:** `DErr` reflects the `Err` sampled at strobe edge k, available immediately after edge k. This is 1 clock after `Err` is stable before the edge.
- **Per-sample response:** a single step in `Err` appears in `DErr` for exactly one sample period. The next strobe returns 0 if `Err` is held.
- **First strobe after reset deassert:** occurs `SAMPLE_DIV` clocks after the cycle in which `rst` is low, counting from counter=0.
- **Critical path:** one W+1-bit subtract plus clamp mux. No multi-cycle paths.

## Structure
- **Shared PID package** (`pid_pkg`), holding:
  - `ERR_W` = 9.
  - `err_t` (signed logic [`ERR_W`−1:0]).
  - Constants `ERR_MAX` = 255 and `ERR_MIN` = −256.
  - This block's `W` default ties to `ERR_W`.
- **Sub-module:** one, `sat_sub`. It performs the W+1-bit signed subtract with clamp and returns the result and an overflow flag. It is reusable by the P/I stages.
- **Top module:** counter, `primed`, and the output registers.

## Test plan
- **Reset/priming:** `rst`=1 for 3 clocks with `Err`=45, then release holding `Err`=45. Required:
  - `DErr`=0 during reset.
  - First strobe gives 0 (prime).
  - Every later strobe gives 0.
- **Step:** after priming at `Err`=0, set `Err`=45 mid-cycle. Required:
  - Next edge: `DErr`=45, `derr_sat`=0.
  - Following edge: 0.
- **Negative step:** `Err` 100 → −20. Required: `DErr`=−120 for one sample, then 0.
- **Saturation:** `Err` −256 → 255 gives `DErr`=255 with `derr_sat`=1. `Err` 255 → −256 gives −256 with `derr_sat`=1. The next sample after each gives 0 with `derr_sat`=0.
- **Decimation:** with `SAMPLE_DIV`=4, change `Err` 10 → 30 between strobes. Required:
  - `DErr` updates only every 4th edge, to 20.
  - `DErr` holds for 3 edges between strobes.
- **Mid-run reset:** assert `rst` while `DErr`=45. Required:
  - `DErr`=0 on that edge.
  - First strobe after release is 0 regardless of the `Err` jump.
